// File: rtl/countdown_controller.sv
// Countdown sequencer: tick prescaler, button edges, IDLE/RUN/PAUSED/DONE FSM; all outputs registered, 1-cycle latency, no backpressure.
// `define COUNTDOWN_AUTO_RELOAD_EN turns expiry into a periodic reload that stays in RUN instead of latching DONE.
module countdown_controller #(
    parameter int TICK_DIV  = 50000000,
    parameter int FLASH_DIV = 12500000,
    parameter int MAX_VAL   = 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_load,
    input  logic [4:0] i_load_val,
    output logic [4:0] o_count,
    output logic       o_tick,
    output logic       o_running,
    output logic       o_expired,
    output logic       o_blank
);

    localparam int PW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
    localparam int FW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
    localparam logic [4:0]    MAX5       = 5'(MAX_VAL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    r_state;
    logic [4:0]    r_count;
    logic [4:0]    r_reload;
    logic [PW-1:0] r_presc;
    logic [FW-1:0] r_flash;
    logic          r_tick;
    logic          r_running;
    logic          r_expired;
    logic          r_blank;
    logic          r_start_prev;
    logic          r_pause_prev;
    logic          r_load_prev;

    logic [1:0]    w_state_nxt;
    logic [4:0]    w_count_nxt;
    logic [4:0]    w_reload_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [FW-1:0] w_flash_nxt;
    logic          w_tick_nxt;
    logic          w_expired_nxt;
    logic          w_blank_nxt;
    logic          w_start_edge;
    logic          w_pause_edge;
    logic          w_load_edge;
    logic          w_tick_due;
    logic [4:0]    w_load_clamp;

    assign w_start_edge = i_start & ~r_start_prev;
    assign w_pause_edge = i_pause & ~r_pause_prev;
    assign w_load_edge  = i_load  & ~r_load_prev;
    assign w_load_clamp = (i_load_val > MAX5) ? MAX5 : i_load_val;
    assign w_tick_due   = (r_state == S_RUN) && (r_presc == TICK_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_reload_nxt  = r_reload;
        w_presc_nxt   = r_presc;
        w_flash_nxt   = '0;
        w_tick_nxt    = 1'b0;
        w_expired_nxt = 1'b0;
        w_blank_nxt   = r_blank;
        case (r_state)
            S_IDLE: begin
                if (w_load_edge) begin
                    w_count_nxt  = w_load_clamp;
                    w_reload_nxt = w_load_clamp;
                end else if (w_start_edge && (r_count != 5'd0)) begin
                    w_state_nxt = S_RUN;
                    w_presc_nxt = '0;
                end
            end
            S_RUN: begin
                w_presc_nxt = w_tick_due ? '0 : r_presc + PW'(1);
                w_tick_nxt  = w_tick_due;
                if (w_tick_due && (r_count == 5'd1)) begin
                    // Expiry outranks any pause/abort edge in the same cycle.
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (r_reload != 5'd0) begin
                        w_count_nxt   = r_reload;
                        w_expired_nxt = 1'b1;
                    end else begin
                        w_count_nxt = 5'd0;
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_count_nxt = 5'd0;
                    w_state_nxt = S_DONE;
                    w_blank_nxt = 1'b0;
`endif
                end else begin
                    if (w_tick_due && (r_count != 5'd0))
                        w_count_nxt = r_count - 5'd1;
                    if (w_pause_edge)
                        w_state_nxt = S_PAUSED;
                    else if (w_start_edge)
                        w_state_nxt = S_IDLE;
                end
            end
            S_PAUSED: begin
                if (w_pause_edge)
                    w_state_nxt = S_RUN;
                else if (w_start_edge)
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_count_nxt = 5'd0;
                if (w_load_edge) begin
                    w_state_nxt  = S_IDLE;
                    w_count_nxt  = w_load_clamp;
                    w_reload_nxt = w_load_clamp;
                    w_blank_nxt  = 1'b0;
                end else if (w_start_edge) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = r_reload;
                    w_blank_nxt = 1'b0;
                end else if (r_flash == FLASH_LAST) begin
                    w_blank_nxt = ~r_blank;
                end else begin
                    w_flash_nxt = r_flash + FW'(1);
                end
            end
        endcase
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        w_expired_nxt = (w_state_nxt == S_DONE);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_count      <= MAX5;
            r_reload     <= MAX5;
            r_presc      <= '0;
            r_flash      <= '0;
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
            r_expired    <= 1'b0;
            r_blank      <= 1'b0;
            r_start_prev <= 1'b1;
            r_pause_prev <= 1'b1;
            r_load_prev  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_reload     <= w_reload_nxt;
            r_presc      <= w_presc_nxt;
            r_flash      <= w_flash_nxt;
            r_tick       <= w_tick_nxt;
            r_running    <= (w_state_nxt == S_RUN);
            r_expired    <= w_expired_nxt;
            r_blank      <= w_blank_nxt;
            r_start_prev <= i_start;
            r_pause_prev <= i_pause;
            r_load_prev  <= i_load;
        end
    end

    assign o_count   = r_count;
    assign o_tick    = r_tick;
    assign o_running = r_running;
    assign o_expired = r_expired;
    assign o_blank   = r_blank;

endmodule

// File: doc/countdown_controller.md
Name: countdown_controller

Overview:
- Sequencing controller for the lab countdown datapath (down counter, digit split, seven-segment decoders).
- Owns the tick prescaler, start/pause/load button handling and run-state FSM.
- Drives a 5-bit count into the existing split/decoder path, plus blank and expired flags for the display.
- Replaces a free-running divided clock with a single-clock tick enable.

Parameters:
- TICK_DIV, 50000000: clk cycles per count tick (1 Hz at 50 MHz); must be >= 2.
- FLASH_DIV, 12500000: clk cycles per blank toggle in DONE; must be >= 2.
- MAX_VAL, 20: largest loadable count; must be <= 31.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  start/abort button, active-high level, rising edge detected internally.
- pause  in  1  pause/resume button, active-high level, rising edge detected internally.
- load  in  1  load strobe, active-high level, rising edge detected internally.
- load_val  in  5  preset value, sampled on the load edge.
- count  out  5  current count value, to split/decoder path.
- tick  out  1  one-cycle pulse on every decrement.
- running  out  1  high in RUN.
- expired  out  1  high in DONE.
- blank  out  1  display blank request; toggles in DONE only.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, count=MAX_VAL, reload register=MAX_VAL.
  - prescaler=0, flash counter=0, tick=0, running=0, expired=0, blank=0.
  - Button history registers=1, so a button held through reset does not produce an edge.
- Edge detect: edge = level & ~prev; prev registered every cycle. Exactly one edge per press. No debounce (handled upstream).
- Load clamp: loaded value = min(load_val, MAX_VAL). It is written to both count and the reload register.
- Prescaler:
  - Increments only in RUN; frozen in PAUSED; cleared on entry to RUN from IDLE.
  - At TICK_DIV-1 it wraps to 0 and tick=1 for that one cycle.
  - First decrement occurs TICK_DIV cycles after the start edge.
- IDLE:
  - load edge -> load the clamped value.
  - start edge with count!=0 -> RUN.
  - start edge with count==0 -> stay in IDLE.
  - pause edge -> ignored.
  - If start and load edges fall in the same cycle, load wins and the state stays IDLE.
- RUN (running=1):
  - tick -> count=count-1.
  - tick with count==1 -> count=0, go to DONE.
  - pause edge -> PAUSED.
  - start edge -> abort to IDLE; count is kept.
  - load edge -> ignored.
  - Simultaneous events: expiry beats pause, then pause beats abort. On any simultaneous edge, the decrement for that tick is still applied.
- PAUSED:
  - pause edge -> RUN; prescaler resumes from its held value.
  - start edge -> IDLE; count is kept.
  - load edge -> ignored.
- DONE (expired=1):
  - count=0.
  - Flash counter runs; blank toggles every FLASH_DIV cycles. First toggle occurs FLASH_DIV cycles after entry.
  - start edge -> IDLE, count=reload register, blank=0.
  - load edge -> IDLE, count=clamped load_val, blank=0.
  - pause edge -> ignored.
- Timing: tick is registered and asserted in the same cycle the new count value appears. All outputs are registered.
- Arithmetic: count never decrements below 0. No wrap-around of count.
- Reset mid-operation: returns to reset values on the next edge regardless of state.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - Expiry in RUN reloads count from the reload register and stays in RUN (periodic timer).
  - expired pulses high for exactly that one cycle.
  - DONE is unreachable and blank stays 0.
  - If the reload register is 0, enter IDLE instead.
- Undefined: behaviour as described above (latches in DONE).

Test Plan (TICK_DIV=4, FLASH_DIV=3, MAX_VAL=20):
- Release reset with start held high -> no edge, state stays IDLE, count=20, all flags 0. Drop start, press start -> running=1; first tick 4 cycles later, count=19.
- load_val=27, load edge -> count=20. Then load_val=3, load edge, start edge -> ticks at +4/+8/+12 cycles give count 2,1,0. At count 0: expired=1, running=0. Blank toggles at 3, 6 and 9 cycles after entry.
- load 5, start, pause edge 2 cycles after the first tick -> count holds at 4 for 20 cycles. Pause edge again -> next tick exactly 2 cycles later, count=3.
- Count=1 in RUN with pause edge in the tick cycle -> DONE, count=0. Pause is ignored.
- In DONE after loading 3: start edge -> IDLE, count=3, blank=0. Start edge with count=0 in IDLE -> stays IDLE.
- With COUNTDOWN_AUTO_RELOAD_EN, load 2, start -> count sequence 1, 0→2 reload; expired is a 1-cycle pulse on the reload cycle and running stays 1.
- Assert reset in PAUSED -> next edge gives count=20 and IDLE.
